popcount_frame_accum: RTL and testbench
=======================================

# popcount_frame_accum

Frame-level accumulator directly downstream of the 32-bit popcount stage. It consumes one per-word popcount value (0..32) per accepted transfer and sums counts over a frame of up to FRAME_LEN words. At frame end it presents the total, the word count and an error flag on a valid/ready output. It turns the word-level popcount into a per-frame bit-density figure for the next consumer.

## Interface
- FRAME_LEN, 16: maximum words per frame; legal range 1..256
- SUM_W, 10: output sum width; must satisfy 2^SUM_W > 32*FRAME_LEN
- WCNT_W, 9: word-count width; must satisfy 2^WCNT_W > FRAME_LEN
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_count/in_last valid
- in_ready  out  1  block accepts input this cycle
- in_count  in  6  popcount of one 32-bit word
- in_last  in  1  early frame terminator, qualified by in_valid
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  SUM_W  sum of in_count over the frame
- out_words  out  WCNT_W  words accepted in the frame, 1..FRAME_LEN
- out_err  out  1  at least one in_count > 32 in the frame
- out_max  out  6  largest in_count in the frame (see Configuration)

## Operation
- Two states: ACCUM (in_ready=1, out_valid=0) and RESULT (in_ready=0, out_valid=1).
- Input accepted when in_valid && in_ready.
- On accept in ACCUM:
  - sum += clamp(in_count)
  - words += 1
  - err |= (in_count > 32)
  - clamp(x) = 32 if x > 32, else x.
- Frame ends on the accepted word where in_last=1 or words reaches FRAME_LEN, whichever comes first.
  - The final word is included in the result.
  - Next state is RESULT, with out_sum/out_words/out_err/out_max registered.
- RESULT: outputs hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear sum, words, err and max; go to ACCUM.
- in_valid while in RESULT is ignored (not accepted). The upstream holds data because in_ready=0.
- in_last on a non-accepted cycle has no effect.
- Sum cannot overflow given the SUM_W constraint; no saturation logic.
- Zero-word frames are impossible: a frame closes only on an accepted word.

## Timing
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_sum=0, out_words=0, out_err=0, out_max=0.
- rst takes effect on the next rising edge. It overrides all other events.
- rst mid-frame or in RESULT discards the partial frame or pending result; no output is produced for it.
- Latency: out_valid rises on the cycle after the edge that accepts the final word.
- Throughput: one word per cycle within a frame.
  - One bubble cycle per frame when out_ready is held at 1: RESULT lasts a minimum of one cycle.
- in_ready is a registered function of state only; no combinational path from out_ready to in_ready.
- Accumulator and state registers only; no combinational input-to-output path on data.

## Configuration
- POPCOUNT_ACCUM_MAX_EN defined:
  - A 6-bit max register tracks the largest clamp(in_count) in the frame.
  - Captured into out_max with the result; cleared with the frame.
- Not defined:
  - No max register.
  - out_max is tied to 0 constantly.
  - Port list is unchanged.

## Structure
- Shared package popcount_pkg holds:
  - POP_WORD_BITS=32
  - POP_CNT_W=6
  - state encoding: ACCUM=1'b0, RESULT=1'b1
  - clamp constant POP_MAX_CNT=32
- No sub-module. A single module holds the state register, accumulator, word counter, err/max registers and output registers.

## Test plan
- Full frame: rst, then 16 words of in_count=3 with out_ready=1 -> after the 16th accept, out_valid=1 for 1 cycle, out_sum=48, out_words=16, out_err=0; in_ready=0 that cycle.
- Early end: counts 32,0,5 with in_last on the 3rd, out_ready=0 for 4 cycles -> out_sum=37, out_words=3, outputs stable for all 4 cycles; in_valid during hold is not accepted; after out_ready, in_ready=1 next cycle.
- Clamp/error: in_count=40 then 10 with in_last -> out_sum=42, out_err=1. The next frame of 1,in_last -> out_err=0, out_sum=1.
- Reset mid-frame: 5 words of 7, assert rst 1 cycle, then 2 words of 1 with in_last -> out_sum=2, out_words=2. No result emitted for the aborted frame.
- Max (macro defined): counts 4,31,9 with in_last -> out_max=31. Without the macro, same stimulus -> out_max=0, out_sum=44.
- Back-to-back frames: FRAME_LEN=1, in_valid held high with in_count=1, out_ready=1 -> alternating accept/result cycles; each result has out_sum=1, out_words=1.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared constants and state encoding for the popcount pipeline stages.
// Used by popcount_frame_accum; the per-word count is 0..32 in a 6-bit field.
package popcount_pkg;

   localparam int POP_WORD_BITS = 32;
   localparam int POP_CNT_W     = 6;
   localparam logic [POP_CNT_W-1:0] POP_MAX_CNT = 6'd32;

   typedef enum logic {
      ACCUM  = 1'b0,
      RESULT = 1'b1
   } accum_state_e;

   // Out-of-range counts (33..63) are treated as a full word.
   function automatic logic [POP_CNT_W-1:0] clamp_cnt(input logic [POP_CNT_W-1:0] x);
      return (x > POP_MAX_CNT) ? POP_MAX_CNT : x;
   endfunction

endpackage

// File: rtl/popcount_frame_accum.sv
// Sums per-word popcounts over a frame and presents total, word count and error on valid/ready.
// Optional per-frame maximum tracking is enabled with POPCOUNT_ACCUM_MAX_EN.
module popcount_frame_accum
   import popcount_pkg::*;
#(
   parameter int FRAME_LEN = 16,
   parameter int SUM_W     = 10,
   parameter int WCNT_W    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_count,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  out_sum,
   output logic [WCNT_W-1:0] out_words,
   output logic              out_err,
   output logic [5:0]        out_max
);

   // Handshake: a transfer occurs on a rising edge where valid && ready; the
   // producer holds its data while ready is low, and ready never depends on valid.
   accum_state_e state;

   logic [SUM_W-1:0]     sum_q;
   logic [WCNT_W-1:0]    words_q;
   logic                 err_q;
   logic                 accept;
   logic                 release_res;
   logic                 frame_end;
   logic [POP_CNT_W-1:0] cnt_c;
   logic [SUM_W-1:0]     sum_n;
   logic [WCNT_W-1:0]    words_n;
   logic                 err_n;

   assign in_ready    = (state == ACCUM);
   assign out_valid   = (state == RESULT);
   assign accept      = in_valid && in_ready;
   assign release_res = out_valid && out_ready;

   assign cnt_c     = clamp_cnt(in_count);
   assign sum_n     = sum_q + SUM_W'(cnt_c);
   assign words_n   = words_q + WCNT_W'(1);
   assign err_n     = err_q | (in_count > POP_MAX_CNT);
   assign frame_end = in_last || (words_n == WCNT_W'(FRAME_LEN));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         sum_q     <= '0;
         words_q   <= '0;
         err_q     <= 1'b0;
         out_sum   <= '0;
         out_words <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  sum_q   <= sum_n;
                  words_q <= words_n;
                  err_q   <= err_n;
                  if (frame_end) begin
                     out_sum   <= sum_n;
                     out_words <= words_n;
                     out_err   <= err_n;
                     state     <= RESULT;
                  end
               end
            end
            RESULT: begin
               if (release_res) begin
                  sum_q   <= '0;
                  words_q <= '0;
                  err_q   <= 1'b0;
                  state   <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

`ifdef POPCOUNT_ACCUM_MAX_EN
   logic [POP_CNT_W-1:0] max_q;
   logic [POP_CNT_W-1:0] max_n;
   logic [POP_CNT_W-1:0] out_max_q;

   assign max_n   = (cnt_c > max_q) ? cnt_c : max_q;
   assign out_max = out_max_q;

   // Follows the same accept/frame-end/release events as the sum accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_q     <= '0;
         out_max_q <= '0;
      end else if (accept) begin
         max_q <= max_n;
         if (frame_end) out_max_q <= max_n;
      end else if (release_res) begin
         max_q <= '0;
      end
   end
`else
   assign out_max = '0;
`endif

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed bench for popcount_frame_accum: default-length instance plus a FRAME_LEN=1 instance.
// Expected out_max follows POPCOUNT_ACCUM_MAX_EN.
module tb_popcount_frame_accum;

`ifdef POPCOUNT_ACCUM_MAX_EN
   localparam bit MAX_EN = 1'b1;
`else
   localparam bit MAX_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       in_valid  = 1'b0;
   logic       in_ready;
   logic [5:0] in_count  = '0;
   logic       in_last   = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [9:0] out_sum;
   logic [8:0] out_words;
   logic       out_err;
   logic [5:0] out_max;

   logic       b_in_valid  = 1'b0;
   logic       b_in_ready;
   logic [5:0] b_in_count  = '0;
   logic       b_in_last   = 1'b0;
   logic       b_out_valid;
   logic       b_out_ready = 1'b1;
   logic [9:0] b_out_sum;
   logic [8:0] b_out_words;
   logic       b_out_err;
   logic [5:0] b_out_max;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   popcount_frame_accum #(.FRAME_LEN(16), .SUM_W(10), .WCNT_W(9)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_words(out_words), .out_err(out_err), .out_max(out_max)
   );

   popcount_frame_accum #(.FRAME_LEN(1), .SUM_W(10), .WCNT_W(9)) dut_b2b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_count(b_in_count), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
      .out_words(b_out_words), .out_err(b_out_err), .out_max(b_out_max)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic send_word(input logic [5:0] c, input logic last);
      @(negedge clk);
      in_valid = 1'b1;
      in_count = c;
      in_last  = last;
   endtask

   task automatic end_frame();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input int sum, input int words,
                               input logic err, input int maxv);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_sum"}, 32'(out_sum), 32'(sum));
      check({tag, "_words"}, 32'(out_words), 32'(words));
      check({tag, "_err"}, 32'(out_err), 32'(err));
      check({tag, "_max"}, 32'(out_max), MAX_EN ? 32'(maxv) : 32'd0);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(out_sum), 32'd0);
      check("rst_words", 32'(out_words), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_max", 32'(out_max), 32'd0);
      rst = 1'b0;

      // full frame closes on FRAME_LEN
      for (int i = 0; i < 16; i++) send_word(6'd3, 1'b0);
      end_frame();
      check_result("full", 48, 16, 1'b0, 3);
      @(negedge clk);
      check("full_oneshot_valid", 32'(out_valid), 32'd0);
      check("full_oneshot_ready", 32'(in_ready), 32'd1);

      // early end, result held while out_ready low, input offered during hold
      out_ready = 1'b0;
      send_word(6'd32, 1'b0);
      send_word(6'd0, 1'b0);
      send_word(6'd5, 1'b1);
      @(negedge clk);
      in_count = 6'd9;
      for (int k = 0; k < 4; k++) begin
         check_result($sformatf("hold%0d", k), 37, 3, 1'b0, 32);
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      @(negedge clk);
      check("release_ready", 32'(in_ready), 32'd1);
      check("release_valid", 32'(out_valid), 32'd0);

      // clamp and error, then error cleared for the next frame
      send_word(6'd40, 1'b0);
      send_word(6'd10, 1'b1);
      end_frame();
      check_result("clamp", 42, 2, 1'b1, 32);
      send_word(6'd1, 1'b1);
      end_frame();
      check_result("clamp_next", 1, 1, 1'b0, 1);

      // reset mid-frame discards the partial frame
      for (int i = 0; i < 5; i++) send_word(6'd7, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_noresult", 32'(out_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_valid", 32'(out_valid), 32'd0);
      send_word(6'd1, 1'b0);
      send_word(6'd1, 1'b1);
      end_frame();
      check_result("after_abort", 2, 2, 1'b0, 1);

      // reset while a result is pending
      send_word(6'd5, 1'b1);
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      check("pend_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      check("pend_rst_valid", 32'(out_valid), 32'd0);
      check("pend_rst_sum", 32'(out_sum), 32'd0);
      check("pend_rst_words", 32'(out_words), 32'd0);

      // max tracking
      send_word(6'd4, 1'b0);
      send_word(6'd31, 1'b0);
      send_word(6'd9, 1'b1);
      end_frame();
      check_result("max", 44, 3, 1'b0, 31);

      // back-to-back frames with FRAME_LEN=1
      for (int i = 0; i < 4; i++) exp_q.push_back(10'd1);
      @(negedge clk);
      b_in_valid  = 1'b1;
      b_in_count  = 6'd1;
      b_out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            check($sformatf("b2b%0d_valid", k), 32'(b_out_valid), 32'd1);
            check($sformatf("b2b%0d_ready", k), 32'(b_in_ready), 32'd0);
            check($sformatf("b2b%0d_words", k), 32'(b_out_words), 32'd1);
            if (b_out_valid && exp_q.size() > 0)
               check($sformatf("b2b%0d_sum", k), 32'(b_out_sum), 32'(exp_q.pop_front()));
         end else begin
            check($sformatf("b2b%0d_valid", k), 32'(b_out_valid), 32'd0);
            check($sformatf("b2b%0d_ready", k), 32'(b_in_ready), 32'd1);
         end
      end
      b_in_valid = 1'b0;
      check("b2b_results_left", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
